vga_rect_stage: RTL

VGA_RECT_STAGE -- requirements
Module: vga_rect_stage

---
 rtl/vga_rect_stage.sv | 133 +++++++++++++
 1 files changed

// File: rtl/vga_rect_stage.sv
// Double-buffered rectangle register for a VGA overlay. Writes are held in a shadow copy and
// only take effect during vertical blanking. Optional border output: define RECT_BORDER_EN.
module vga_rect_stage (
  input  logic        clock,
  input  logic        reset,
  input  logic [63:0] poswh_in,
  input  logic        wr_en,
  input  logic        blank,
  input  logic        pix_valid,
  input  logic [9:0]  pix_x,
  input  logic [9:0]  pix_y,
  output logic        busy,
  output logic        wr_ack,
  output logic        in_rect,
  output logic [63:0] rect_active,
  output logic [7:0]  frame_count,
`ifdef RECT_BORDER_EN
  output logic        border_hit,
`endif
  output logic [1:0]  state_dbg
);

  // Write handshake: wr_en is accepted in IDLE and PENDING. busy stays high from the cycle after
  // the accepted write until the held rectangle is committed. wr_ack pulses in the COMMIT cycle.
  // rect_active takes the new value in the cycle after that. wr_en is ignored during COMMIT.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    COMMIT  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [63:0] shadow_q, shadow_d;
  logic [63:0] rect_q, rect_d;
  logic        wr_ack_q, wr_ack_d;
  logic        blank_q;
  logic [7:0]  frame_q, frame_d;
  logic        in_rect_q, in_rect_d;

  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    rect_d   = rect_q;
    case (state_q)
      IDLE: begin
        if (wr_en) begin
          shadow_d = poswh_in;
          state_d  = PENDING;
        end
      end
      PENDING: begin
        if (wr_en) shadow_d = poswh_in;
        if (blank) state_d = COMMIT;
      end
      COMMIT: begin
        rect_d  = shadow_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    wr_ack_d = (state_d == COMMIT);
  end

  always_comb begin
    frame_d = frame_q;
    if (blank && !blank_q) frame_d = frame_q + 8'd1;
  end

  // Window compare against the active rectangle; the end sums carry a 17th bit so a rectangle
  // near 0xFFFF never wraps around to cover low coordinates.
  logic [15:0] rx, ry, rw, rh;
  logic [16:0] px17, py17, x_end, y_end;
  logic        hit_x, hit_y;

  always_comb begin
    rx    = rect_q[63:48];
    ry    = rect_q[47:32];
    rw    = rect_q[31:16];
    rh    = rect_q[15:0];
    px17  = {7'd0, pix_x};
    py17  = {7'd0, pix_y};
    x_end = {1'b0, rx} + {1'b0, rw};
    y_end = {1'b0, ry} + {1'b0, rh};
    hit_x = (px17 >= {1'b0, rx}) && (px17 < x_end);
    hit_y = (py17 >= {1'b0, ry}) && (py17 < y_end);
    in_rect_d = pix_valid && hit_x && hit_y;
  end

`ifdef RECT_BORDER_EN
  logic border_q, border_d;

  always_comb begin
    border_d = in_rect_d &&
               ((px17 == {1'b0, rx}) || (px17 == x_end - 17'd1) ||
                (py17 == {1'b0, ry}) || (py17 == y_end - 17'd1));
  end

  always_ff @(posedge clock) begin
    if (reset) border_q <= 1'b0;
    else       border_q <= border_d;
  end

  assign border_hit = border_q;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      shadow_q  <= 64'd0;
      rect_q    <= 64'd0;
      wr_ack_q  <= 1'b0;
      blank_q   <= 1'b0;
      frame_q   <= 8'd0;
      in_rect_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      shadow_q  <= shadow_d;
      rect_q    <= rect_d;
      wr_ack_q  <= wr_ack_d;
      blank_q   <= blank;
      frame_q   <= frame_d;
      in_rect_q <= in_rect_d;
    end
  end

  assign busy        = (state_q != IDLE);
  assign wr_ack      = wr_ack_q;
  assign in_rect     = in_rect_q;
  assign rect_active = rect_q;
  assign frame_count = frame_q;
  assign state_dbg   = state_q;

endmodule
